// File: rtl/mem_sram_ctrl_pkg.sv
// mem_sram_ctrl_pkg: MEM_* operation codes, SRAM FSM states and op helpers
// shared by the SRAM controller and its lane aligner.
package mem_sram_ctrl_pkg;

   localparam logic [3:0] MEM_NOP = 4'd0;
   localparam logic [3:0] MEM_LB  = 4'd1;
   localparam logic [3:0] MEM_LBU = 4'd2;
   localparam logic [3:0] MEM_LH  = 4'd3;
   localparam logic [3:0] MEM_LHU = 4'd4;
   localparam logic [3:0] MEM_LW  = 4'd5;
   localparam logic [3:0] MEM_SB  = 4'd6;
   localparam logic [3:0] MEM_SH  = 4'd7;
   localparam logic [3:0] MEM_SW  = 4'd8;

   typedef enum logic [1:0] {
      SRAM_IDLE   = 2'd0,
      SRAM_ACCESS = 2'd1,
      SRAM_DONE   = 2'd2
   } sram_state_t;

   // Codes outside LB..SW behave exactly like MEM_NOP.
   function automatic logic op_is_valid(input logic [3:0] op);
      return (op >= MEM_LB) && (op <= MEM_SW);
   endfunction

   function automatic logic op_is_store(input logic [3:0] op);
      return (op == MEM_SB) || (op == MEM_SH) || (op == MEM_SW);
   endfunction

endpackage

// File: rtl/mem_sram_ctrl_lane_align.sv
// mem_sram_ctrl_lane_align: little-endian byte-lane enables, store-data
// replication and load extraction with sign/zero extension.
module mem_sram_ctrl_lane_align
   import mem_sram_ctrl_pkg::*;
(
   input  logic [3:0]  i_req_op,
   input  logic [1:0]  i_req_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_rsp_op,
   input  logic [1:0]  i_rsp_addr,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be_n,
   output logic [31:0] o_wdata,
   output logic [31:0] o_ldata
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      o_be_n  = 4'b1111;
      o_wdata = i_wdata;
      case (i_req_op)
         MEM_LW, MEM_SW: o_be_n = 4'b0000;
         MEM_LH, MEM_LHU, MEM_SH: begin
            o_be_n  = i_req_addr[1] ? 4'b0011 : 4'b1100;
            o_wdata = {2{i_wdata[15:0]}};
         end
         MEM_LB, MEM_LBU, MEM_SB: begin
            o_be_n  = ~(4'b0001 << i_req_addr);
            o_wdata = {4{i_wdata[7:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      w_byte = i_rdata[7:0];
      case (i_rsp_addr)
         2'd1:    w_byte = i_rdata[15:8];
         2'd2:    w_byte = i_rdata[23:16];
         2'd3:    w_byte = i_rdata[31:24];
         default: w_byte = i_rdata[7:0];
      endcase
   end

   assign w_half = i_rsp_addr[1] ? i_rdata[31:16] : i_rdata[15:0];

   // Stores and idle codes fall through to zero.
   always_comb begin
      o_ldata = '0;
      case (i_rsp_op)
         MEM_LB:  o_ldata = {{24{w_byte[7]}}, w_byte};
         MEM_LBU: o_ldata = {24'd0, w_byte};
         MEM_LH:  o_ldata = {{16{w_half[15]}}, w_half};
         MEM_LHU: o_ldata = {16'd0, w_half};
         MEM_LW:  o_ldata = i_rdata;
         default: o_ldata = '0;
      endcase
   end

endmodule

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: fixed-latency responder between the MEM stage and an
// asynchronous 32-bit SRAM; IDLE -> ACCESS x WAIT_CYCLES -> DONE.
module mem_sram_ctrl
   import mem_sram_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 2,
   parameter int SRAM_AW     = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         ramOp_i,
   input  logic [31:0]        ramAddr_i,
   input  logic [31:0]        storeData_i,
   output logic               success_o,
   output logic [31:0]        loadData_o,
   output logic [SRAM_AW-1:0] sram_addr_o,
   output logic [31:0]        sram_wdata_o,
   output logic               sram_wdata_oe_o,
   input  logic [31:0]        sram_rdata_i,
   output logic               sram_ce_n_o,
   output logic               sram_oe_n_o,
   output logic               sram_we_n_o,
   output logic [3:0]         sram_be_n_o
);

   localparam int CW = (WAIT_CYCLES > 2) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_INIT = CW'(WAIT_CYCLES - 1);

   sram_state_t   r_state;
   logic [CW-1:0] r_cnt;
   logic [3:0]    r_op;
   logic [1:0]    r_lane;

   logic        w_req;
   logic        w_store;
   logic [3:0]  w_be_n;
   logic [31:0] w_wdata;
   logic [31:0] w_ldata;
   logic        w_unused;

   assign w_req    = op_is_valid(ramOp_i);
   assign w_store  = op_is_store(ramOp_i);
   assign w_unused = ^ramAddr_i[31:SRAM_AW+2];

   mem_sram_ctrl_lane_align u_align (
      .i_req_op   (ramOp_i),
      .i_req_addr (ramAddr_i[1:0]),
      .i_wdata    (storeData_i),
      .i_rsp_op   (r_op),
      .i_rsp_addr (r_lane),
      .i_rdata    (sram_rdata_i),
      .o_be_n     (w_be_n),
      .o_wdata    (w_wdata),
      .o_ldata    (w_ldata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= SRAM_IDLE;
         r_cnt           <= '0;
         r_op            <= MEM_NOP;
         r_lane          <= '0;
         success_o       <= 1'b0;
         loadData_o      <= '0;
         sram_addr_o     <= '0;
         sram_wdata_o    <= '0;
         sram_wdata_oe_o <= 1'b0;
         sram_ce_n_o     <= 1'b1;
         sram_oe_n_o     <= 1'b1;
         sram_we_n_o     <= 1'b1;
         sram_be_n_o     <= 4'hF;
      end else begin
         success_o <= 1'b0;
         unique case (r_state)
            SRAM_IDLE: begin
               if (w_req) begin
                  r_state         <= SRAM_ACCESS;
                  r_cnt           <= CNT_INIT;
                  r_op            <= ramOp_i;
                  r_lane          <= ramAddr_i[1:0];
                  sram_addr_o     <= ramAddr_i[SRAM_AW+1:2];
                  sram_wdata_o    <= w_wdata;
                  sram_be_n_o     <= w_be_n;
                  sram_ce_n_o     <= 1'b0;
                  sram_oe_n_o     <= w_store;
                  sram_we_n_o     <= ~w_store;
                  sram_wdata_oe_o <= w_store;
               end
            end
            SRAM_ACCESS: begin
               // A flush (op dropped to NOP) ends the access without success.
               if (!w_req || r_cnt == '0) begin
                  r_state         <= w_req ? SRAM_DONE : SRAM_IDLE;
                  success_o       <= w_req;
                  if (w_req) loadData_o <= w_ldata;
                  sram_wdata_oe_o <= 1'b0;
                  sram_ce_n_o     <= 1'b1;
                  sram_oe_n_o     <= 1'b1;
                  sram_we_n_o     <= 1'b1;
                  sram_be_n_o     <= 4'hF;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
                  // Raise we_n one cycle early so data outlives the strobe.
                  if (r_cnt == CW'(1)) sram_we_n_o <= 1'b1;
               end
            end
            SRAM_DONE: r_state <= SRAM_IDLE;
            default:   r_state <= SRAM_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: randomized scoreboard bench with a byte-level reference
// memory and a pad-level SRAM model.
module tb_mem_sram_ctrl;
   import mem_sram_ctrl_pkg::*;

   localparam int W  = 2;
   localparam int AW = 20;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [3:0]    ramOp = MEM_NOP;
   logic [31:0]   ramAddr = '0;
   logic [31:0]   storeData = '0;
   logic          success;
   logic [31:0]   loadData;
   logic [AW-1:0] sram_addr;
   logic [31:0]   sram_wdata;
   logic          sram_wdata_oe;
   logic [31:0]   sram_rdata;
   logic          sram_ce_n;
   logic          sram_oe_n;
   logic          sram_we_n;
   logic [3:0]    sram_be_n;

   mem_sram_ctrl #(.WAIT_CYCLES(W), .SRAM_AW(AW)) dut (
      .clk             (clk),
      .rst             (rst),
      .ramOp_i         (ramOp),
      .ramAddr_i       (ramAddr),
      .storeData_i     (storeData),
      .success_o       (success),
      .loadData_o      (loadData),
      .sram_addr_o     (sram_addr),
      .sram_wdata_o    (sram_wdata),
      .sram_wdata_oe_o (sram_wdata_oe),
      .sram_rdata_i    (sram_rdata),
      .sram_ce_n_o     (sram_ce_n),
      .sram_oe_n_o     (sram_oe_n),
      .sram_we_n_o     (sram_we_n),
      .sram_be_n_o     (sram_be_n)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // Pad-level SRAM: a write lands when we_n rises while the chip is
   // still selected and data is still driven.
   logic [31:0] init_mem [16];
   logic [31:0] pad_mem  [16];
   bit          pad_init = 0;
   logic        prev_we  = 1'b1;

   assign sram_rdata = (!sram_ce_n && !sram_oe_n) ?
                       pad_mem[sram_addr[3:0]] : 32'hDEAD_BEEF;

   always @(negedge clk) begin
      if (!pad_init) begin
         for (int i = 0; i < 16; i++) pad_mem[i] = init_mem[i];
         pad_init = 1;
      end
      if (!prev_we && sram_we_n && !sram_ce_n && sram_wdata_oe)
         for (int i = 0; i < 4; i++)
            if (!sram_be_n[i])
               pad_mem[sram_addr[3:0]][8*i +: 8] = sram_wdata[8*i +: 8];
      prev_we = sram_we_n;
   end

   // Reference model at the byte/lane level.
   logic [31:0] ref_mem [16];

   function automatic int op_size(input logic [3:0] op);
      if (op == MEM_LB || op == MEM_LBU || op == MEM_SB) return 1;
      if (op == MEM_LH || op == MEM_LHU || op == MEM_SH) return 2;
      return 4;
   endfunction

   function automatic bit op_st(input logic [3:0] op);
      return op == MEM_SB || op == MEM_SH || op == MEM_SW;
   endfunction

   function automatic logic [31:0] ref_load(input logic [3:0] op,
                                            input logic [31:0] addr);
      logic [31:0] w;
      logic [31:0] v;
      int off;
      int sz;
      w   = ref_mem[addr[5:2]];
      off = int'(addr[1:0]);
      sz  = op_size(op);
      v   = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
      if ((op == MEM_LB || op == MEM_LH) && v[8*sz-1])
         for (int i = sz; i < 4; i++) v[8*i +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic ref_store(input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] data);
      int off;
      int sz;
      off = int'(addr[1:0]);
      sz  = op_size(op);
      for (int i = 0; i < sz; i++)
         ref_mem[addr[5:2]][8*(off+i) +: 8] = data[8*i +: 8];
   endtask

   typedef struct {
      logic [31:0]   data;
      int            due;
      bit            st;
      logic [3:0]    be_n;
      logic [AW-1:0] addr;
      logic [31:0]   wdata;
   } exp_t;

   exp_t q[$];

   task automatic push_exp(input logic [3:0] op, input logic [31:0] addr,
                           input logic [31:0] data, input int issue);
      exp_t e;
      int sz;
      int off;
      sz  = op_size(op);
      off = int'(addr[1:0]);
      e.st = op_st(op);
      if (e.st) begin
         ref_store(op, addr, data);
         e.data = '0;
      end else begin
         e.data = ref_load(op, addr);
      end
      e.due  = issue + 1 + W;
      e.be_n = 4'hF;
      for (int i = 0; i < sz; i++) e.be_n[off+i] = 1'b0;
      e.addr = addr[AW+1:2];
      for (int i = 0; i < 4; i++)
         e.wdata[8*i +: 8] = data[8*(i % sz) +: 8];
      q.push_back(e);
   endtask

   // Monitor: per-access strobe statistics, compared on each success.
   exp_t          me;
   int            ce_cnt  = 0;
   int            we_cnt  = 0;
   int            oe_cnt  = 0;
   int            doe_cnt = 0;
   logic [3:0]    be_seen;
   logic [AW-1:0] addr_seen;
   logic [31:0]   wd_seen;
   logic [31:0]   last_data = '0;

   always @(negedge clk) begin
      if (success) begin
         last_data = loadData;
         if (q.size() == 0) begin
            chk("unexpected_success", 32'd1, 32'd0);
         end else begin
            me = q.pop_front();
            chk("load_data", loadData, me.data);
            chk("latency_cycle", cyc, me.due);
            chk("ce_low_cycles", ce_cnt, W);
            chk("we_low_cycles", we_cnt, me.st ? W - 1 : 0);
            chk("oe_low_cycles", oe_cnt, me.st ? 0 : W);
            chk("wdata_oe_cycles", doe_cnt, me.st ? W : 0);
            chk("be_n", {28'd0, be_seen}, {28'd0, me.be_n});
            chk("sram_addr", {12'd0, addr_seen}, {12'd0, me.addr});
            if (me.st) chk("sram_wdata", wd_seen, me.wdata);
            chk("done_strobes_idle",
                {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe,
                 (sram_be_n == 4'hF)}, 32'b11101);
         end
         ce_cnt = 0; we_cnt = 0; oe_cnt = 0; doe_cnt = 0;
      end else if (sram_ce_n) begin
         ce_cnt = 0; we_cnt = 0; oe_cnt = 0; doe_cnt = 0;
      end else begin
         ce_cnt++;
         if (!sram_we_n) we_cnt++;
         if (!sram_oe_n) oe_cnt++;
         if (sram_wdata_oe) doe_cnt++;
         be_seen   = sram_be_n;
         addr_seen = sram_addr;
         wd_seen   = sram_wdata;
      end
   end

   task automatic do_req(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input int reps);
      int k;
      @(posedge clk); #1;
      ramOp     = op;
      ramAddr   = addr;
      storeData = data;
      push_exp(op, addr, data, cyc);
      for (int r = 0; r < reps; r++) begin
         k = 0;
         do begin
            @(posedge clk); #1;
            k++;
         end while (!success && k < 20);
         if (!success) chk("success_timeout", 32'd0, 32'd1);
         if (r < reps - 1) push_exp(op, addr, data, cyc + 1);
      end
      ramOp = MEM_NOP;
   endtask

   task automatic check_reset(input string nm);
      chk({nm, "_success"}, {31'd0, success}, 32'd0);
      chk({nm, "_load"}, loadData, 32'd0);
      chk({nm, "_strobes"},
          {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe},
          32'b1110);
      chk({nm, "_be_n"}, {28'd0, sram_be_n}, 32'hF);
      chk({nm, "_addr"}, {12'd0, sram_addr}, 32'd0);
      chk({nm, "_wdata"}, sram_wdata, 32'd0);
   endtask

   task automatic settle();
      @(negedge clk); #1;
   endtask

   logic [3:0] ops [8];
   logic [3:0] op;
   logic [31:0] a;
   int sz;
   int k;
   logic [15:0] old_lo;

   initial begin
      ops = '{MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW};
      for (int i = 0; i < 16; i++) init_mem[i] = $urandom;
      init_mem[4] = 32'h8765_4321;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_mem[i];
      old_lo = init_mem[8][15:0];

      repeat (3) @(posedge clk);
      #1;
      check_reset("por");
      rst = 1'b0;

      do_req(MEM_LW, 32'h10, 32'h0, 1);
      settle();
      chk("lw_0x10", last_data, 32'h8765_4321);
      do_req(MEM_LB, 32'h13, 32'h0, 1);
      settle();
      chk("lb_0x13", last_data, 32'hFFFF_FF87);
      do_req(MEM_LBU, 32'h13, 32'h0, 1);
      settle();
      chk("lbu_0x13", last_data, 32'h0000_0087);
      do_req(MEM_SH, 32'h22, 32'h0000_BEEF, 1);
      do_req(MEM_LW, 32'h20, 32'h0, 1);
      settle();
      chk("sh_then_lw", last_data, {16'hBEEF, old_lo});

      // Store flushed in its first ACCESS cycle.
      @(posedge clk); #1;
      ramOp = MEM_SW; ramAddr = 32'h30; storeData = 32'h1234_5678;
      @(posedge clk); #1;
      chk("abort_we_active", {31'd0, sram_we_n}, 32'd0);
      ramOp = MEM_NOP;
      @(posedge clk); #1;
      chk("abort_strobes",
          {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_wdata_oe}, 32'b1110);
      repeat (4) @(posedge clk);
      do_req(MEM_LW, 32'h30, 32'h0, 1);
      settle();
      chk("abort_old_value", last_data, init_mem[12]);

      // Reset in the second ACCESS cycle of a load.
      @(posedge clk); #1;
      ramOp = MEM_LW; ramAddr = 32'h14;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1; ramOp = MEM_NOP;
      @(posedge clk); #1;
      check_reset("rst_mid");
      rst = 1'b0;
      repeat (3) @(posedge clk);

      // Unknown op codes behave as NOP.
      @(posedge clk); #1;
      ramOp = 4'hB;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("unknown_op_idle", {31'd0, sram_ce_n}, 32'd1);
      end
      ramOp = MEM_NOP;

      // Request held past DONE re-executes.
      do_req(MEM_LW, 32'h10, 32'h0, 2);
      settle();
      chk("held_lw_repeat", last_data, 32'h8765_4321);

      for (int n = 0; n < 200; n++) begin
         op = ops[$urandom_range(0, 7)];
         sz = op_size(op);
         a  = {26'd0, 4'($urandom_range(0, 15)), 2'd0};
         if (sz == 1) a[1:0] = 2'($urandom_range(0, 3));
         if (sz == 2) a[1]   = 1'($urandom_range(0, 1));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         do_req(op, a, $urandom, ($urandom_range(0, 7) == 0) ? 2 : 1);
      end

      k = 0;
      while (q.size() != 0 && k < 20) begin
         @(posedge clk);
         k++;
      end
      repeat (3) @(posedge clk);
      chk("queue_drained", q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
